if_neuron_array: RTL and testbench

Time-multiplexed array of `N` integrate-and-fire neurons with on-chip membrane-state and spike-count storage, driven by a valid/ready command stream. It sits between the synaptic event scheduler and the forward-forward learning logic. It replaces per-neuron combinational update with three operations: synaptic accumulation, a time-step fire sweep and a time-reference reset. Fired neuron addresses leave on a back-pressured spike stream.

---
 rtl/if_neuron_array.sv | 211 +++++++++++++++++++++
 tb/tb_if_neuron_array.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_neuron_array.sv
// if_neuron_array: time-multiplexed integrate-and-fire neuron array.
// Commands (SYN / STEP / REF / NOP) arrive on a valid/ready stream. A STEP
// sweeps every neuron once in address order and emits fired addresses
// through a single-entry, back-pressured spike slot.
module if_neuron_array #(
  parameter int N        = 256,
  parameter int AW       = $clog2(N),
  parameter int STATE_W  = 12,
  parameter int WEIGHT_W = 8,
  parameter int CNT_W    = 7
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [WEIGHT_W-1:0] cmd_weight,
  input  logic [STATE_W-1:0]  param_thr,
  output logic                spike_valid,
  input  logic                spike_ready,
  output logic [AW-1:0]       spike_addr,
  output logic                busy,
  input  logic [AW-1:0]       rd_addr,
  output logic [STATE_W-1:0]  rd_state,
  output logic [CNT_W-1:0]    rd_cnt
);

  localparam logic [1:0] OP_SYN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_REF  = 2'b10;

  localparam logic [STATE_W-1:0] ST_MAX = {1'b0, {(STATE_W-1){1'b1}}};
  localparam logic [STATE_W-1:0] ST_MIN = {1'b1, {(STATE_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
  // One bit wider than the address so that N itself is representable.
  localparam logic [AW:0]        ADDR_LIMIT = (AW+1)'(N);
  localparam logic [AW-1:0]      LAST_IDX   = AW'(N-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_DRAIN = 2'd2
  } fsm_t;

  fsm_t fsm_reg, fsm_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          spike_valid_reg;
  logic [AW-1:0] spike_addr_reg;
  logic [STATE_W-1:0] rd_state_reg;
  logic [CNT_W-1:0]   rd_cnt_reg;

  // Per-neuron storage, exported as flat arrays for the shared read muxes.
  logic [STATE_W-1:0] state_q [N];
  logic [CNT_W-1:0]   cnt_q   [N];

  // Decoded command strobes.
  logic cmd_fire;
  logic syn_we;
  logic ref_clr;
  logic step_go;
  logic sweep_go;
  logic fire;
  logic slot_free;

  // Shared arithmetic on the addressed / swept neuron.
  logic [STATE_W-1:0] syn_cur;
  logic [STATE_W:0]   syn_sum;
  logic [STATE_W-1:0] syn_sat;
  logic [STATE_W-1:0] sweep_cur;
  logic [STATE_W-1:0] rd_state_mux;
  logic [CNT_W-1:0]   rd_cnt_mux;

  assign cmd_ready = (fsm_reg == S_IDLE) && !RST;
  assign busy      = (fsm_reg != S_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign syn_we    = cmd_fire && (cmd_op == OP_SYN) && ({1'b0, cmd_addr} < ADDR_LIMIT);
  assign ref_clr   = cmd_fire && (cmd_op == OP_REF);
  assign step_go   = cmd_fire && (cmd_op == OP_STEP);
  // The slot can take a new spike when empty or when its content leaves now.
  assign slot_free = !spike_valid_reg || spike_ready;
  assign sweep_go  = (fsm_reg == S_STEP) && slot_free;

  // Read muxes built from comparators so the address width may exceed $clog2(N).
  always_comb begin
    syn_cur      = '0;
    sweep_cur    = '0;
    rd_state_mux = '0;
    rd_cnt_mux   = '0;
    for (int k = 0; k < N; k++) begin
      if (cmd_addr == AW'(k)) syn_cur = state_q[k];
      if (idx_reg == AW'(k)) sweep_cur = state_q[k];
      if (rd_addr == AW'(k)) begin
        rd_state_mux = state_q[k];
        rd_cnt_mux   = cnt_q[k];
      end
    end
  end

  // Saturating accumulate: one guard bit detects overflow in either direction.
  always_comb begin
    syn_sum = {syn_cur[STATE_W-1], syn_cur}
            + {{(STATE_W+1-WEIGHT_W){cmd_weight[WEIGHT_W-1]}}, cmd_weight};
    syn_sat = syn_sum[STATE_W-1:0];
    if (syn_sum[STATE_W] != syn_sum[STATE_W-1]) begin
      syn_sat = syn_sum[STATE_W] ? ST_MIN : ST_MAX;
    end
  end

  // Threshold is non-negative, so a non-negative state compares correctly unsigned.
  assign fire = !sweep_cur[STATE_W-1] && (sweep_cur >= param_thr);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_neuron
      logic [STATE_W-1:0] st_reg;
      logic [CNT_W-1:0]   cnt_reg;
      logic               syn_hit;
      logic               fire_hit;

      assign syn_hit  = syn_we && (cmd_addr == AW'(gi));
      assign fire_hit = sweep_go && fire && (idx_reg == AW'(gi));
      assign state_q[gi] = st_reg;
      assign cnt_q[gi]   = cnt_reg;

      // Neuron update: clear on reset/REF, accumulate on SYN, reset and count on fire.
      always_ff @(posedge CLK) begin
        if (RST || ref_clr) begin
          st_reg  <= '0;
          cnt_reg <= '0;
        end else if (syn_hit) begin
          st_reg <= syn_sat;
        end else if (fire_hit) begin
          st_reg  <= '0;
          cnt_reg <= (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_reg <= S_IDLE;
      idx_reg <= '0;
    end else begin
      fsm_reg <= fsm_next;
      idx_reg <= idx_next;
    end
  end

  // Sequencer next state: IDLE -> STEP on accepted STEP, N sweep slots, then DRAIN.
  always_comb begin
    fsm_next = fsm_reg;
    idx_next = idx_reg;
    case (fsm_reg)
      S_IDLE: begin
        if (step_go) begin
          fsm_next = S_STEP;
          idx_next = '0;
        end
      end
      S_STEP: begin
        if (sweep_go) begin
          if (idx_reg == LAST_IDX) begin
            fsm_next = S_DRAIN;
          end else begin
            idx_next = idx_reg + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (slot_free) fsm_next = S_IDLE;
      end
      default: begin
        fsm_next = S_IDLE;
        idx_next = '0;
      end
    endcase
  end

  // Single-entry spike slot: load on fire, empty on accept, otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      spike_valid_reg <= 1'b0;
      spike_addr_reg  <= '0;
    end else if (sweep_go && fire) begin
      spike_valid_reg <= 1'b1;
      spike_addr_reg  <= idx_reg;
    end else if (spike_ready) begin
      spike_valid_reg <= 1'b0;
    end
  end

  assign spike_valid = spike_valid_reg;
  assign spike_addr  = spike_addr_reg;

  // Registered read port; shows pre-write contents when a write lands the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_state_reg <= '0;
      rd_cnt_reg   <= '0;
    end else begin
      rd_state_reg <= rd_state_mux;
      rd_cnt_reg   <= rd_cnt_mux;
    end
  end

  assign rd_state = rd_state_reg;
  assign rd_cnt   = rd_cnt_reg;

endmodule

// File: tb/tb_if_neuron_array.sv
// Directed testbench for if_neuron_array with N=4, STATE_W=12, CNT_W=3.
module tb_if_neuron_array;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b11;
  logic [2:0]  cmd_addr = '0;
  logic [7:0]  cmd_weight = '0;
  logic [11:0] param_thr = 12'd10;
  logic        spike_valid;
  logic        spike_ready = 1'b1;
  logic [2:0]  spike_addr;
  logic        busy;
  logic [2:0]  rd_addr = '0;
  logic [11:0] rd_state;
  logic [2:0]  rd_cnt;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [2:0] spk_q[$];

  localparam logic [1:0] SYN = 2'b00, STEP = 2'b01, REF = 2'b10, NOP = 2'b11;

  if_neuron_array #(.N(4), .AW(3), .STATE_W(12), .WEIGHT_W(8), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_weight(cmd_weight), .param_thr(param_thr),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_addr(spike_addr),
    .busy(busy), .rd_addr(rd_addr), .rd_state(rd_state), .rd_cnt(rd_cnt)
  );

  always #5 CLK = ~CLK;

  // Record every spike handed over; inputs only change just after rising edges.
  always @(negedge CLK) begin
    if (!RST && spike_valid && spike_ready) spk_q.push_back(spike_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] w);
    int b;
    @(negedge CLK);
    cmd_op = op; cmd_addr = addr; cmd_weight = w; cmd_valid = 1'b1;
    b = 0;
    while (!cmd_ready && b < 100) begin
      @(negedge CLK);
      b++;
    end
    if (!cmd_ready) chk("cmd_accept", cmd_ready, 1);
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for cmd_ready, counting rising edges since the accept edge.
  task automatic wait_idle(input int start, output int n);
    n = start;
    while (!cmd_ready && n < 200) begin
      @(posedge CLK);
      #1 n++;
    end
  endtask

  task automatic run_step(input string tag, input int exp_lat);
    int n;
    send(STEP, 3'd0, 8'd0);
    chk({tag, "_busy"}, busy, 1);
    wait_idle(0, n);
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [11:0] es, input logic [2:0] ec);
    rd_addr = a;
    @(posedge CLK);
    #1;
    chk({tag, "_state"}, rd_state, es);
    chk({tag, "_cnt"}, rd_cnt, ec);
  endtask

  // Compare recorded spikes against up to four expected addresses packed 3 bits each.
  task automatic chk_spikes(input string tag, input int n, input logic [11:0] addrs);
    chk({tag, "_nspk"}, spk_q.size(), n);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_spk"}, (k < spk_q.size()) ? {29'd0, spk_q[k]} : 32'hFFFF, addrs[3*k +: 3]);
    end
    spk_q.delete();
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_spike_addr", spike_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_state", rd_state, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    RST = 1'b0;
    #1 chk("post_rst_ready", cmd_ready, 1);

    // Basic integrate and fire, back-to-back SYN to one address.
    send(SYN, 3'd2, 8'd7);
    send(SYN, 3'd2, 8'd5);
    send(SYN, 3'd1, 8'd3);
    rd_chk("acc2", 3'd2, 12'd12, 3'd0);
    run_step("step1", 5);
    chk_spikes("step1", 1, 12'o0002);
    rd_chk("fired2", 3'd2, 12'd0, 3'd1);
    rd_chk("kept1", 3'd1, 12'd3, 3'd0);
    rd_chk("kept0", 3'd0, 12'd0, 3'd0);

    // Saturation in both directions; only the positive rail fires at thr=2047.
    send(REF, 3'd0, 8'd0);
    rd_chk("ref1", 3'd1, 12'd0, 3'd0);
    rd_chk("ref2", 3'd2, 12'd0, 3'd0);
    for (int k = 0; k < 20; k++) send(SYN, 3'd0, 8'd127);
    for (int k = 0; k < 20; k++) send(SYN, 3'd1, 8'h80);
    rd_chk("sat_pos", 3'd0, 12'd2047, 3'd0);
    rd_chk("sat_neg", 3'd1, 12'h800, 3'd0);
    param_thr = 12'd2047;
    run_step("step_sat", 5);
    chk_spikes("step_sat", 1, 12'o0000);
    rd_chk("sat_fired0", 3'd0, 12'd0, 3'd1);
    rd_chk("sat_keep1", 3'd1, 12'h800, 3'd0);

    // Spike-count saturation at 7 while spikes keep coming.
    send(REF, 3'd0, 8'd0);
    param_thr = 12'd10;
    for (int r = 0; r < 9; r++) begin
      send(SYN, 3'd0, 8'd10);
      run_step("cnt_round", 5);
      chk_spikes("cnt_round", 1, 12'o0000);
    end
    rd_chk("cnt_sat", 3'd0, 12'd0, 3'd7);

    // NOP and out-of-range SYN leave everything alone.
    send(SYN, 3'd1, 8'd5);
    send(NOP, 3'd1, 8'd50);
    send(SYN, 3'd4, 8'd100);
    rd_chk("nop_n1", 3'd1, 12'd5, 3'd0);
    rd_chk("oor_n0", 3'd0, 12'd0, 3'd7);
    rd_chk("oor_n3", 3'd3, 12'd0, 3'd0);
    rd_chk("oor_rd4", 3'd4, 12'd0, 3'd0);

    // Back-pressure: hold spike_ready low for 5 cycles after the first spike.
    send(REF, 3'd0, 8'd0);
    for (int k = 0; k < 4; k++) send(SYN, 3'(k), 8'd20);
    send(STEP, 3'd0, 8'd0);
    cyc = 0;
    while (!spike_valid && cyc < 50) begin
      @(posedge CLK);
      #1 cyc++;
    end
    chk("bp_first_cycle", cyc, 1);
    spike_ready = 1'b0;
    repeat (5) begin
      @(posedge CLK);
      #1 cyc++;
      chk("bp_hold_valid", spike_valid, 1);
      chk("bp_hold_addr", spike_addr, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_busy", busy, 1);
    end
    spike_ready = 1'b1;
    wait_idle(cyc, cyc);
    chk("bp_latency", cyc, 10);
    chk_spikes("bp", 4, {3'd3, 3'd2, 3'd1, 3'd0});
    rd_chk("bp_n3", 3'd3, 12'd0, 3'd1);

    // REF after spikes clears every state and count.
    send(REF, 3'd0, 8'd0);
    for (int k = 0; k < 4; k++) rd_chk("ref_all", 3'(k), 12'd0, 3'd0);

    // Reset in the middle of a sweep (index 2).
    for (int k = 0; k < 4; k++) send(SYN, 3'(k), 8'd20);
    send(STEP, 3'd0, 8'd0);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rst_spike_valid", spike_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    RST = 1'b0;
    #1 chk("mid_rst_ready_after", cmd_ready, 1);
    spk_q.delete();
    for (int k = 0; k < 4; k++) rd_chk("mid_rst_clear", 3'(k), 12'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
